// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready read port of the UART receive FIFO.
// The master drives the head word and valid; the slave returns ready.
interface uart_rx_fifo_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a show-ahead FIFO with a valid/ready read side.
// Reports framing errors, parity errors and overruns as one-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the data bits
// (sense chosen by PARITY_ODD); without it parity_err is tied low.
module uart_rx_fifo #(
   parameter int unsigned CLK_HZ     = 12_500_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                        sysclk,
   input  logic                        rst_n,
   input  logic                        uart_txd_in,
   uart_rx_fifo_if.master              m,
   output logic                        frame_err,
   output logic                        parity_err,
   output logic                        overrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned ScW   = $clog2(OVERSAMPLE);
   localparam int unsigned BitW  = $clog2(DATA_BITS);
   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

   localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
   localparam logic [ScW-1:0]  ScLast  = ScW'(OVERSAMPLE - 1);
   localparam logic [ScW-1:0]  ScSamp0 = ScW'(OVERSAMPLE / 2 - 1);
   localparam logic [ScW-1:0]  ScSamp1 = ScW'(OVERSAMPLE / 2);
   localparam logic [ScW-1:0]  ScDec   = ScW'(OVERSAMPLE / 2 + 1);
   localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
   localparam logic [AddrW:0]  Full    = (AddrW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } state_e;

`ifdef UART_RX_PARITY_EN
   localparam state_e AfterData = StParity;
`else
   localparam state_e AfterData = StStop;
`endif

   // ---------------------------------------------------------------- synchroniser
   logic rx_meta_q, rxs;

   // Two-flop synchroniser; resets high so reset release never looks like a start bit
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rxs       <= 1'b1;
      end else begin
         rx_meta_q <= uart_txd_in;
         rxs       <= rx_meta_q;
      end
   end

   // ---------------------------------------------------------------- tick generator
   logic [DivW-1:0] div_q;
   logic            tick;

   assign tick = (div_q == DivLast);

   // Free-running oversample divider, never realigned to the frame
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------- receive FSM
   state_e               state_q;
   logic [ScW-1:0]       sc_q;
   logic [ScW-1:0]       sc_inc;
   logic [BitW-1:0]      bit_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 samp0_q, samp1_q;
   logic                 push_q;
   logic                 vote, decide;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q;
`endif

   assign sc_inc = (sc_q == ScLast) ? '0 : sc_q + 1'b1;
   assign decide = tick && (sc_q == ScDec);
   // Majority of the two stored samples and the live one taken at the decision tick
   assign vote   = (samp0_q & samp1_q) | (samp0_q & rxs) | (samp1_q & rxs);

   // Frame state machine; bit periods end on sc wrap so each new state starts at sc = 0
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sc_q      <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         samp0_q   <= 1'b1;
         samp1_q   <= 1'b1;
         push_q    <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q     <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         push_q    <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (tick && sc_q == ScSamp0) samp0_q <= rxs;
         if (tick && sc_q == ScSamp1) samp1_q <= rxs;

         case (state_q)
            StIdle: begin
               sc_q <= '0;
               if (!rxs) state_q <= StStart;
            end
            StStart: begin
               if (tick) begin
                  sc_q <= sc_inc;
                  if (decide && vote) begin
                     // Start bit did not hold low to mid-bit: treat as a glitch
                     state_q <= StIdle;
                     sc_q    <= '0;
                  end else if (sc_q == ScLast) begin
                     state_q <= StData;
                     bit_q   <= '0;
                  end
               end
            end
            StData: begin
               if (tick) begin
                  sc_q <= sc_inc;
                  if (decide) shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
                  if (sc_q == ScLast) begin
                     if (bit_q == BitLast) state_q <= AfterData;
                     else                  bit_q   <= bit_q + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (tick) begin
                  sc_q <= sc_inc;
                  if (decide) perr_q <= ((^shreg_q) ^ vote) != PARITY_ODD[0];
                  if (sc_q == ScLast) state_q <= StStop;
               end
            end
`endif
            StStop: begin
               if (tick) begin
                  sc_q <= sc_inc;
                  if (decide) begin
                     // Leave mid-stop so a back-to-back start edge is not missed
                     sc_q <= '0;
                     if (!vote) begin
                        frame_err <= 1'b1;
                        state_q   <= StBreak;
`ifdef UART_RX_PARITY_EN
                     end else if (perr_q) begin
                        parity_err <= 1'b1;
                        state_q    <= StIdle;
`endif
                     end else begin
                        push_q  <= 1'b1;
                        state_q <= StIdle;
                     end
                  end
               end
            end
            StBreak: begin
               sc_q <= '0;
               if (rxs) state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               sc_q    <= '0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   // PARITY_ODD has no meaning without a parity bit
   assign parity_err = 1'b0 & PARITY_ODD[0];
`endif

   // ---------------------------------------------------------------- output FIFO
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AddrW:0]       count_q;
   logic                 empty, full, pop, push;

   assign empty = (count_q == '0);
   assign full  = (count_q == Full);
   assign pop   = m.ready && !empty;
   assign push  = push_q && (!full || pop);

   // Storage array; contents are don't-care until written
   always_ff @(posedge sysclk) begin
      if (push) mem_q[wr_ptr_q] <= shreg_q;
   end

   // Pointers, occupancy and overrun pulse; pointers wrap since depth is a power of two
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         overrun  <= 1'b0;
      end else begin
         overrun <= push_q && !push;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign m.valid    = !empty;
   assign m.data     = empty ? '0 : mem_q[rd_ptr_q];
   assign fifo_level = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at a scaled line rate (32 clocks per bit).
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

   localparam int unsigned CLK_HZ = 3_200_000;
   localparam int unsigned BAUD   = 100_000;
   localparam int unsigned OS     = 16;
   localparam int unsigned DB     = 8;
   localparam int unsigned FD     = 16;
   localparam int unsigned PODD   = 0;
   localparam int          BIT    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
   localparam int          STOP_IDX = DB + 2;
`else
   localparam int          STOP_IDX = DB + 1;
`endif

   logic       sysclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_txd_in = 1'b1;
   logic       frame_err, parity_err, overrun;
   logic [4:0] fifo_level;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
   int fe0, pe0, ov0;
   int lat;

   uart_rx_fifo_if #(.DATA_BITS(DB)) rx_if ();

   uart_rx_fifo #(
      .CLK_HZ    (CLK_HZ),
      .BAUD      (BAUD),
      .OVERSAMPLE(OS),
      .DATA_BITS (DB),
      .FIFO_DEPTH(FD),
      .PARITY_ODD(PODD)
   ) dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .uart_txd_in(uart_txd_in),
      .m          (rx_if.master),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .fifo_level (fifo_level)
   );

   always #5 sysclk = ~sysclk;

   // Pulse counters
   always @(negedge sysclk) begin
      if (frame_err === 1'b1)  fe_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
      if (overrun === 1'b1)    ov_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ PODD[0];
   endfunction

   // Start, data LSB first, optional parity, stop; line is left at the stop value
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      uart_txd_in = 1'b0;
      cycles(BIT);
      for (int i = 0; i < int'(DB); i++) begin
         uart_txd_in = d[i];
         cycles(BIT);
      end
`ifdef UART_RX_PARITY_EN
      uart_txd_in = par;
      cycles(BIT);
`else
      if (par === 1'bz) uart_txd_in = 1'b1;
`endif
      uart_txd_in = stop;
      cycles(BIT);
   endtask

   task automatic send_good(input logic [7:0] d);
      send_frame(d, good_par(d), 1'b1);
      uart_txd_in = 1'b1;
   endtask

   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (rx_if.valid !== 1'b1 && n < max) begin
         @(negedge sysclk);
         n++;
      end
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      @(negedge sysclk);
      check({tag, "_valid"}, rx_if.valid, 1);
      check({tag, "_data"}, rx_if.data, exp);
      @(posedge sysclk);
      #1;
      rx_if.ready = 1'b1;
      cycles(1);
      rx_if.ready = 1'b0;
   endtask

   initial begin
      rx_if.ready = 1'b0;

      // Reset state
      cycles(3);
      @(negedge sysclk);
      check("rst_valid", rx_if.valid, 0);
      check("rst_data", rx_if.data, 0);
      check("rst_level", fifo_level, 0);
      check("rst_flags", {frame_err, parity_err, overrun}, 0);
      @(posedge sysclk);
      #1;
      rst_n = 1'b1;
      cycles(2 * BIT);

      // Single word 0xA5 and its latency to m_valid
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      fork
         send_good(8'hA5);
         wait_valid(14 * BIT, lat);
      join
      check("a5_latency_window", (lat >= STOP_IDX * BIT) && (lat <= (STOP_IDX + 1) * BIT), 1);
      @(negedge sysclk);
      check("a5_level", fifo_level, 1);
      pop_check("a5", 8'hA5);
      @(negedge sysclk);
      check("a5_level_after_pop", fifo_level, 0);
      check("a5_no_flags", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
      cycles(BIT);

      // 31 back-to-back words into a 16-deep FIFO with no consumer
      ov0 = ov_cnt;
      for (int i = 0; i < 31; i++) send_good(8'(i));
      cycles(2 * BIT);
      @(negedge sysclk);
      check("ovr_level", fifo_level, 16);
      check("ovr_pulses", ov_cnt - ov0, 15);
      for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i), 8'(i));
      @(negedge sysclk);
      check("drain_level", fifo_level, 0);
      check("drain_valid", rx_if.valid, 0);

      // Framing error with the line held low, then recovery
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      @(posedge sysclk);
      #1;
      send_frame(8'h3C, good_par(8'h3C), 1'b0);
      cycles(3 * BIT);
      uart_txd_in = 1'b1;
      cycles(2 * BIT);
      @(negedge sysclk);
      check("fe_pulses", fe_cnt - fe0, 1);
      check("fe_level", fifo_level, 0);
      check("fe_other_flags", (pe_cnt - pe0) + (ov_cnt - ov0), 0);
      @(posedge sysclk);
      #1;
      send_good(8'h11);
      cycles(BIT);
      @(negedge sysclk);
      check("after_fe_level", fifo_level, 1);
      pop_check("after_fe", 8'h11);

      // Short low glitch on an idle line
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      @(posedge sysclk);
      #1;
      uart_txd_in = 1'b0;
      cycles(8);
      uart_txd_in = 1'b1;
      cycles(3 * BIT);
      @(negedge sysclk);
      check("glitch_level", fifo_level, 0);
      check("glitch_valid", rx_if.valid, 0);
      check("glitch_flags", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong
      pe0 = pe_cnt;
      @(posedge sysclk);
      #1;
      send_frame(8'h07, 1'b1, 1'b1);
      uart_txd_in = 1'b1;
      cycles(BIT);
      @(negedge sysclk);
      check("par_ok_level", fifo_level, 1);
      check("par_ok_no_pe", pe_cnt - pe0, 0);
      pop_check("par_ok", 8'h07);
      @(posedge sysclk);
      #1;
      send_frame(8'h07, 1'b0, 1'b1);
      uart_txd_in = 1'b1;
      cycles(BIT);
      @(negedge sysclk);
      check("par_bad_pulse", pe_cnt - pe0, 1);
      check("par_bad_level", fifo_level, 0);
`endif

      // Reset during data bit 4 with two words buffered
      @(posedge sysclk);
      #1;
      send_good(8'h01);
      send_good(8'h02);
      cycles(BIT);
      @(negedge sysclk);
      check("pre_rst_level", fifo_level, 2);
      @(posedge sysclk);
      #1;
      uart_txd_in = 1'b0;
      cycles(BIT);
      uart_txd_in = 1'b1; cycles(BIT);
      uart_txd_in = 1'b0; cycles(BIT);
      uart_txd_in = 1'b1; cycles(BIT);
      uart_txd_in = 1'b0; cycles(BIT);
      uart_txd_in = 1'b1; cycles(BIT / 2);
      rst_n = 1'b0;
      #2;
      check("midrst_level", fifo_level, 0);
      check("midrst_valid", rx_if.valid, 0);
      check("midrst_data", rx_if.data, 0);
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      cycles(4);
      rst_n = 1'b1;
      cycles(2 * BIT);
      send_good(8'h5A);
      cycles(BIT);
      @(negedge sysclk);
      check("post_rst_level", fifo_level, 1);
      check("post_rst_data", rx_if.data, 8'h5A);
      check("post_rst_flags", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
